cordic_phase_gen: RTL and testbench
===================================

# cordic_phase_gen

Upstream control stage for the pipelined CORDIC sine/cosine rotator. It generates a burst of 32-bit phase words by phase accumulation, `angle = offset + k·ftw mod 2^32`, and drives them into the rotator's `angle` input. It tracks the rotator's fixed pipeline latency so that `sample_valid` lines up with the rotator's `Xout`/`Yout`. It also reports `busy`/`done` to the sequencing logic.

## Interface
- `PHASE_W`, 32: phase word width. It equals the rotator's angle width; full scale 2^32 = 2π, and the top 2 bits select the quadrant.
- `CNT_W`, 16: width of the burst length and sample counter.
- `CORDIC_LAT`, 16: rotator latency in clocks from `angle` capture to valid `Xout`/`Yout`. This is 1 pre-rotation stage plus 15 iteration stages for a 16-bit datapath.

Ports:
- `clock` in 1: single clock for the block; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a burst; sampled only in IDLE.
- `stop` in 1: end the burst early; sampled only in RUN.
- `ftw` in PHASE_W: frequency tuning word, unsigned; latched at start.
- `phase_off` in PHASE_W: phase offset; latched at start.
- `burst_len` in CNT_W: number of samples; 0 means continuous until `stop`. Latched at start.
- `angle` out PHASE_W: registered phase word; connects to the rotator's `angle`.
- `angle_valid` out 1: `angle` is a live sample this cycle.
- `sample_valid` out 1: rotator outputs correspond to a live sample this cycle.
- `busy` out 1: burst or drain in progress.
- `done` out 1: one-cycle pulse when the burst is fully drained.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- **IDLE**
  - `start`=1 latches `ftw_l`, `off_l` and `len_l`, then moves to RUN.
  - On the same edge: `angle` ← `phase_off`, `acc` ← `ftw`, `cnt` ← 1, `angle_valid` ← 1.
  - `stop` is ignored in IDLE.
- **RUN**, evaluated each edge, in priority order:
  - If `stop`=1: `angle_valid` ← 0 and go to DRAIN. The sample shown during the stop cycle counts as emitted.
  - Else if `len_l`≠0 and `cnt`==`len_l`: `angle_valid` ← 0 and go to DRAIN.
  - Otherwise: `angle` ← `acc + off_l`, `acc` ← `acc + ftw_l`, `cnt` ← `cnt+1`, and `angle_valid` stays 1.
  - `start` is ignored in RUN.
- **DRAIN**
  - `dcnt` counts CORDIC_LAT cycles.
  - On its final edge, `done` ← 1 for one cycle and the state returns to IDLE.
  - `start` is ignored in DRAIN.
- Arithmetic:
  - All phase sums are modulo 2^PHASE_W; wrap-around is intended (2π ≡ 0). There is no saturation.
  - `cnt` is CNT_W wide.
  - In continuous mode (`len_l`=0), `cnt` may wrap freely and has no effect.
- Valid alignment:
  - A CORDIC_LAT-deep shift register is fed by `angle_valid`; `sample_valid` is its tail.
  - The shift register shifts every cycle in every state.
- `busy` = (state ≠ IDLE).
- `angle` holds its last value when not valid.
- **Reset**
  - Asserting `reset_n`=0 clears the state to IDLE, and clears `acc`, `cnt`, `dcnt`, the latched registers and the shift register.
  - All outputs are 0 while in reset: `angle`=0, `angle_valid`=0, `sample_valid`=0, `busy`=0, `done`=0.
  - Reset mid-burst therefore produces no `sample_valid` for samples already in flight in the rotator.

## Timing
- `start` high in cycle T (IDLE):
  - `busy` and `angle_valid` go high in cycle T+1.
  - Sample k (k = 0…N−1) is present on `angle` in cycle T+1+k.
- The rotator captures sample k at the end of cycle T+1+k. The matching `sample_valid` is high in cycle T+1+k+CORDIC_LAT.
- Burst of N samples:
  - `angle_valid` is high in cycles T+1 … T+N.
  - DRAIN spans T+N+1 … T+N+CORDIC_LAT.
  - The last `sample_valid` is in cycle T+N+CORDIC_LAT.
  - `done` is high and `busy` is low in cycle T+N+CORDIC_LAT+1.
- `stop` high in RUN cycle S: the last valid sample is in S, and `done` fires in cycle S+CORDIC_LAT+1.
- When `stop` and burst completion occur in the same cycle, the result is identical (`stop` has priority).
- A new `start` is accepted in the cycle `done` is high, since the block is already in IDLE. Back-to-back bursts are separated by CORDIC_LAT+1 idle `angle_valid` cycles.
- `burst_len`=1: exactly one sample, at T+1.

## Test plan
- **Basic burst.** Stimulus: `ftw`=0x0400_0000, `phase_off`=0x4000_0000, `burst_len`=4, `start` in cycle T.
  - `angle` = 0x4000_0000, 0x4400_0000, 0x4800_0000, 0x4C00_0000 in T+1…T+4.
  - `sample_valid` is high in T+17…T+20.
  - `done` is high only in T+21; `busy` is high T+1…T+20.
- **Wrap-around.** Stimulus: `ftw`=0x8000_0000, `phase_off`=0xC000_0000, `burst_len`=3.
  - `angle` = 0xC000_0000, 0x4000_0000, 0xC000_0000 (quadrants 11, 01, 11).
  - `done` at T+20.
- **Continuous then stop.** Stimulus: `burst_len`=0, `ftw`=1, `phase_off`=0; `stop` high in T+10.
  - 10 samples, 0…9.
  - `angle_valid` is low from T+11.
  - `done` at T+27.
  - `stop` pulsed in IDLE beforehand has no effect.
- **Ignored start.** Stimulus: a second `start` with a different `ftw` is pulsed during RUN and again during DRAIN.
  - There is no restart, and the angle sequence is unchanged.
  - A `start` in the `done` cycle launches a new burst with its first sample on the next cycle.
- **Reset mid-burst.** Stimulus: `reset_n` low for 2 cycles at T+3 during a 10-sample burst.
  - All outputs are 0 immediately and asynchronously.
  - No `sample_valid` appears over the following 20 cycles.
  - `start` after release behaves as in the basic burst scenario.
- **Single sample.** Stimulus: `burst_len`=1.
  - One `angle_valid` cycle at T+1, one `sample_valid` at T+17, and `done` at T+18.

Source files
------------

// File: rtl/cordic_phase_gen_if.sv
// Control and data bundle between the phase generator and its sequencer/rotator.
// The sequencer (master) issues start/stop and burst parameters; the phase
// generator (slave) returns the phase word and status flags.
interface cordic_phase_gen_if #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] phase_off;
    logic [CNT_W-1:0]   burst_len;
    logic [PHASE_W-1:0] angle;
    logic               angle_valid;
    logic               sample_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, ftw, phase_off, burst_len,
        input  angle, angle_valid, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, ftw, phase_off, burst_len,
        output angle, angle_valid, sample_valid, busy, done
    );
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase-accumulating burst generator feeding a pipelined CORDIC rotator.
// Emits angle = offset + k*ftw (mod 2^PHASE_W) for a burst, then drains for the
// rotator latency so sample_valid lines up with the rotator outputs.
module cordic_phase_gen #(
    parameter int PHASE_W    = 32,
    parameter int CNT_W      = 16,
    parameter int CORDIC_LAT = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    cordic_phase_gen_if.slave  bus
);
    localparam int DCNT_W = $clog2(CORDIC_LAT + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(CORDIC_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PHASE_W-1:0]     ftw_l;
    logic [PHASE_W-1:0]     off_l;
    logic [CNT_W-1:0]       len_l;
    logic [PHASE_W-1:0]     acc;
    logic [CNT_W-1:0]       cnt;
    logic [DCNT_W-1:0]      dcnt;
    logic [PHASE_W-1:0]     angle_r;
    logic                   angle_valid_r;
    logic [CORDIC_LAT-1:0]  vld_sr;
    logic                   done_r;
    logic                   end_run;
    logic                   drain_last;
    logic                   busy_c;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; stop outranks length completion, both end the run
    always_comb begin
        state_next = state;
        end_run    = bus.stop || ((len_l != '0) && (cnt == len_l));
        drain_last = (dcnt == DCNT_LAST);
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (end_run)   state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational status outputs
    always_comb begin
        busy_c = (state != IDLE);
    end

    // Phase datapath: latch parameters at launch, accumulate while running
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ftw_l         <= '0;
            off_l         <= '0;
            len_l         <= '0;
            acc           <= '0;
            cnt           <= '0;
            dcnt          <= '0;
            angle_r       <= '0;
            angle_valid_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= (state == DRAIN) && drain_last;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ftw_l         <= bus.ftw;
                        off_l         <= bus.phase_off;
                        len_l         <= bus.burst_len;
                        angle_r       <= bus.phase_off;
                        acc           <= bus.ftw;
                        cnt           <= CNT_W'(1);
                        angle_valid_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (end_run) begin
                        angle_valid_r <= 1'b0;
                        dcnt          <= '0;
                    end else begin
                        angle_r <= acc + off_l;
                        acc     <= acc + ftw_l;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + DCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Valid delay line matching the rotator latency; shifts every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_sr <= '0;
        else          vld_sr <= {vld_sr[CORDIC_LAT-2:0], angle_valid_r};
    end

    assign bus.angle        = angle_r;
    assign bus.angle_valid  = angle_valid_r;
    assign bus.sample_valid = vld_sr[CORDIC_LAT-1];
    assign bus.busy         = busy_c;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: per-cycle capture after a start,
// compared against hand-derived expected sequences.
module tb_cordic_phase_gen;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] cap_angle [0:40];
    logic        cap_av    [0:40];
    logic        cap_sv    [0:40];
    logic        cap_busy  [0:40];
    logic        cap_done  [0:40];

    cordic_phase_gen_if #(.PHASE_W(32), .CNT_W(16)) bus ();

    cordic_phase_gen #(.PHASE_W(32), .CNT_W(16), .CORDIC_LAT(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.ftw       = '0;
        bus.phase_off = '0;
        bus.burst_len = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Raise start in cycle T (this negedge); parameters presented alongside
    task automatic launch(input logic [31:0] f, input logic [31:0] o, input logic [15:0] n);
        @(negedge clock);
        bus.ftw       = f;
        bus.phase_off = o;
        bus.burst_len = n;
        bus.start     = 1'b1;
    endtask

    // Sample cycles T+1..T+n; optional stop cycle and extra start pulses
    task automatic capture(input int n, input int stop_at, input int rs_a, input int rs_b, input int rs_c);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            bus.start = (i == rs_a) || (i == rs_b) || (i == rs_c);
            if (bus.start) begin
                bus.ftw       = 32'h7000_0000;
                bus.phase_off = 32'h1234_5678;
            end
            bus.stop     = (i == stop_at);
            cap_angle[i] = bus.angle;
            cap_av[i]    = bus.angle_valid;
            cap_sv[i]    = bus.sample_valid;
            cap_busy[i]  = bus.busy;
            cap_done[i]  = bus.done;
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.angle, bus.angle_valid, bus.sample_valid, bus.busy, bus.done} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got angle=%h av=%b sv=%b busy=%b done=%b expected all zero",
                     bus.angle, bus.angle_valid, bus.sample_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ea;
        do_reset();
        launch(32'h0400_0000, 32'h4000_0000, 16'd4);
        capture(22, -1, -1, -1, -1);
        for (int i = 1; i <= 22; i++) begin
            ea = (i <= 4) ? 32'h4000_0000 + 32'(i - 1) * 32'h0400_0000 : 32'h4C00_0000;
            checks++;
            if (cap_angle[i] !== ea) begin
                errors++; $display("FAIL basic_angle cycle %0d got %h expected %h", i, cap_angle[i], ea);
            end
            checks++;
            if (cap_av[i] !== (i <= 4)) begin
                errors++; $display("FAIL basic_av cycle %0d got %b expected %b", i, cap_av[i], (i <= 4));
            end
            checks++;
            if (cap_sv[i] !== (i >= 17 && i <= 20)) begin
                errors++; $display("FAIL basic_sv cycle %0d got %b expected %b", i, cap_sv[i], (i >= 17 && i <= 20));
            end
            checks++;
            if (cap_busy[i] !== (i <= 20)) begin
                errors++; $display("FAIL basic_busy cycle %0d got %b expected %b", i, cap_busy[i], (i <= 20));
            end
            checks++;
            if (cap_done[i] !== (i == 21)) begin
                errors++; $display("FAIL basic_done cycle %0d got %b expected %b", i, cap_done[i], (i == 21));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [1:3];
        exp_a[1] = 32'hC000_0000; exp_a[2] = 32'h4000_0000; exp_a[3] = 32'hC000_0000;
        do_reset();
        launch(32'h8000_0000, 32'hC000_0000, 16'd3);
        capture(21, -1, -1, -1, -1);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (cap_angle[i] !== exp_a[i]) begin
                errors++; $display("FAIL wrap_angle cycle %0d got %h expected %h", i, cap_angle[i], exp_a[i]);
            end
        end
        for (int i = 1; i <= 21; i++) begin
            checks++;
            if (cap_done[i] !== (i == 20)) begin
                errors++; $display("FAIL wrap_done cycle %0d got %b expected %b", i, cap_done[i], (i == 20));
            end
        end
    endtask

    task automatic test_continuous_stop();
        do_reset();
        @(negedge clock);
        bus.stop = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.angle_valid !== 1'b0) begin
            errors++; $display("FAIL idle_stop got busy=%b av=%b expected 0 0", bus.busy, bus.angle_valid);
        end
        bus.stop = 1'b0;
        launch(32'h0000_0001, 32'h0000_0000, 16'd0);
        capture(28, 10, -1, -1, -1);
        for (int i = 1; i <= 28; i++) begin
            checks++;
            if (cap_angle[i] !== ((i <= 10) ? 32'(i - 1) : 32'd9)) begin
                errors++; $display("FAIL cont_angle cycle %0d got %h expected %h", i, cap_angle[i], ((i <= 10) ? 32'(i - 1) : 32'd9));
            end
            checks++;
            if (cap_av[i] !== (i <= 10)) begin
                errors++; $display("FAIL cont_av cycle %0d got %b expected %b", i, cap_av[i], (i <= 10));
            end
            checks++;
            if (cap_sv[i] !== (i >= 17 && i <= 26)) begin
                errors++; $display("FAIL cont_sv cycle %0d got %b expected %b", i, cap_sv[i], (i >= 17 && i <= 26));
            end
            checks++;
            if (cap_done[i] !== (i == 27)) begin
                errors++; $display("FAIL cont_done cycle %0d got %b expected %b", i, cap_done[i], (i == 27));
            end
        end
    endtask

    task automatic test_ignored_start();
        do_reset();
        launch(32'h0100_0000, 32'h0000_0000, 16'd5);
        capture(24, -1, 2, 10, 22);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (cap_angle[i] !== 32'(i - 1) << 24) begin
                errors++; $display("FAIL ign_angle cycle %0d got %h expected %h", i, cap_angle[i], 32'(i - 1) << 24);
            end
        end
        for (int i = 1; i <= 22; i++) begin
            checks++;
            if (cap_av[i] !== (i <= 5)) begin
                errors++; $display("FAIL ign_av cycle %0d got %b expected %b", i, cap_av[i], (i <= 5));
            end
            checks++;
            if (cap_done[i] !== (i == 22)) begin
                errors++; $display("FAIL ign_done cycle %0d got %b expected %b", i, cap_done[i], (i == 22));
            end
        end
        checks++;
        if (cap_av[23] !== 1'b1 || cap_angle[23] !== 32'h1234_5678) begin
            errors++; $display("FAIL restart_first got av=%b angle=%h expected 1 12345678", cap_av[23], cap_angle[23]);
        end
        checks++;
        if (cap_av[24] !== 1'b1 || cap_angle[24] !== 32'h8234_5678) begin
            errors++; $display("FAIL restart_second got av=%b angle=%h expected 1 82345678", cap_av[24], cap_angle[24]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int sv_seen;
        do_reset();
        launch(32'h0400_0000, 32'h4000_0000, 16'd10);
        capture(3, -1, -1, -1, -1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.angle, bus.angle_valid, bus.sample_valid, bus.busy, bus.done} !== 36'h0) begin
            errors++;
            $display("FAIL async_reset got angle=%h av=%b sv=%b busy=%b done=%b expected all zero",
                     bus.angle, bus.angle_valid, bus.sample_valid, bus.busy, bus.done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.sample_valid === 1'b1) sv_seen++;
        end
        checks++;
        if (sv_seen !== 0) begin
            errors++; $display("FAIL post_reset_sv got %0d valid cycles expected 0", sv_seen);
        end
        launch(32'h0400_0000, 32'h4000_0000, 16'd4);
        capture(22, -1, -1, -1, -1);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (cap_angle[i] !== 32'h4000_0000 + 32'(i - 1) * 32'h0400_0000) begin
                errors++; $display("FAIL rerun_angle cycle %0d got %h expected %h", i, cap_angle[i], 32'h4000_0000 + 32'(i - 1) * 32'h0400_0000);
            end
        end
        for (int i = 1; i <= 22; i++) begin
            checks++;
            if (cap_done[i] !== (i == 21)) begin
                errors++; $display("FAIL rerun_done cycle %0d got %b expected %b", i, cap_done[i], (i == 21));
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        launch(32'h1111_1111, 32'hABCD_0000, 16'd1);
        capture(20, -1, -1, -1, -1);
        checks++;
        if (cap_angle[1] !== 32'hABCD_0000) begin
            errors++; $display("FAIL single_angle got %h expected abcd0000", cap_angle[1]);
        end
        for (int i = 1; i <= 20; i++) begin
            checks++;
            if (cap_av[i] !== (i == 1)) begin
                errors++; $display("FAIL single_av cycle %0d got %b expected %b", i, cap_av[i], (i == 1));
            end
            checks++;
            if (cap_sv[i] !== (i == 17)) begin
                errors++; $display("FAIL single_sv cycle %0d got %b expected %b", i, cap_sv[i], (i == 17));
            end
            checks++;
            if (cap_done[i] !== (i == 18)) begin
                errors++; $display("FAIL single_done cycle %0d got %b expected %b", i, cap_done[i], (i == 18));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_continuous_stop();
        test_ignored_start();
        test_reset_mid_burst();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
